// File: rtl/alu_cmd_queue_if.sv
// Command/issue bundle between the command source, alu_cmd_queue and the ALU.
// master drives commands and the issue throttle; slave is the queue itself.
interface alu_cmd_queue_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             issue_en;
    logic [1:0]       op_out;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic [7:0]       err_cnt;

    modport master (
        output cmd_op, cmd_a, cmd_b, cmd_valid, issue_en,
        input  cmd_ready, op_out, a_out, b_out, out_valid, count, err_cnt
    );

    modport slave (
        input  cmd_op, cmd_a, cmd_b, cmd_valid, issue_en,
        output cmd_ready, op_out, a_out, b_out, out_valid, count, err_cnt
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Issue stage for the registered add/sub ALU: buffers commands in a small
// FIFO, issues one per cycle while issue_en is high, and drops and counts
// illegal opcodes.
module alu_cmd_queue #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] OP_ILLEGAL = 2'h3;

    logic [1:0]       mem_op_q [DEPTH];
    logic [WIDTH-1:0] mem_a_q  [DEPTH];
    logic [WIDTH-1:0] mem_b_q  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [1:0]       op_out_q, op_out_d;
    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;
    logic             out_valid_q, out_valid_d;

    logic ready;
    logic accept;
    logic push;
    logic illegal;
    logic pop;

    // Handshake decode; ready comes from registered occupancy only, so a pop
    // on a full cycle does not open the input.
    always_comb begin
        ready   = (count_q != CW'(DEPTH));
        accept  = bus.cmd_valid && ready;
        push    = accept && (bus.cmd_op != OP_ILLEGAL);
        illegal = accept && (bus.cmd_op == OP_ILLEGAL);
        pop     = bus.issue_en && (count_q != '0);
    end

    // Next-state for pointers, occupancy, error counter and issue registers.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_cnt_d   = err_cnt_q;
        op_out_d    = '0;
        a_out_d     = '0;
        b_out_d     = '0;
        out_valid_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            op_out_d    = mem_op_q[rd_ptr_q];
            a_out_d     = mem_a_q[rd_ptr_q];
            b_out_d     = mem_b_q[rd_ptr_q];
            out_valid_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (illegal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_cnt_q   <= '0;
            op_out_q    <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_cnt_q   <= err_cnt_d;
            op_out_q    <= op_out_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FIFO storage; contents are not reset, reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_op_q[wr_ptr_q] <= bus.cmd_op;
            mem_a_q[wr_ptr_q]  <= bus.cmd_a;
            mem_b_q[wr_ptr_q]  <= bus.cmd_b;
        end
    end

    // Drive interface outputs.
    always_comb begin
        bus.cmd_ready = ready;
        bus.op_out    = op_out_q;
        bus.a_out     = a_out_q;
        bus.b_out     = b_out_q;
        bus.out_valid = out_valid_q;
        bus.count     = count_q;
        bus.err_cnt   = err_cnt_q;
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue: each accepted legal command is queued
// as an expected issue and compared when the queue pops it.
module tb_alu_cmd_queue;
    localparam int WIDTH = 6;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } ent_t;

    logic clk;
    logic rst;

    alu_cmd_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    alu_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t sb[$];
    int   exp_err;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, predict, then compare after the edge.
    task automatic step(input logic v, input logic [1:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ien);
        int   n;
        bit   rdy;
        bit   pop;
        bit   acc;
        ent_t e;
        n   = sb.size();
        rdy = (n != DEPTH);
        pop = ien && (n != 0);
        acc = v && rdy;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.issue_en  = ien;
        #0;
        check_eq("cmd_ready", int'(bus.cmd_ready), int'(rdy));
        @(posedge clk);
        #1;
        if (pop) begin
            e = sb.pop_front();
            check_eq("out_valid", int'(bus.out_valid), 1);
            check_eq("op_out", int'(bus.op_out), int'(e.op));
            check_eq("a_out", int'(bus.a_out), int'(e.a));
            check_eq("b_out", int'(bus.b_out), int'(e.b));
        end else begin
            check_eq("idle_valid", int'(bus.out_valid), 0);
            check_eq("idle_op", int'(bus.op_out), 0);
            check_eq("idle_a", int'(bus.a_out), 0);
            check_eq("idle_b", int'(bus.b_out), 0);
        end
        if (acc) begin
            if (op != 2'h3) begin
                e.op = op;
                e.a  = a;
                e.b  = b;
                sb.push_back(e);
            end else if (exp_err != 255) begin
                exp_err++;
            end
        end
        check_eq("count", int'(bus.count), sb.size());
        check_eq("err_cnt", int'(bus.err_cnt), exp_err);
    endtask

    // Reset edge with a command and issue request presented; both must be ignored.
    task automatic do_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'h1;
        bus.cmd_a     = 6'd33;
        bus.cmd_b     = 6'd22;
        bus.issue_en  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_err = 0;
        check_eq("rst_valid", int'(bus.out_valid), 0);
        check_eq("rst_op", int'(bus.op_out), 0);
        check_eq("rst_a", int'(bus.a_out), 0);
        check_eq("rst_b", int'(bus.b_out), 0);
        check_eq("rst_count", int'(bus.count), 0);
        check_eq("rst_err", int'(bus.err_cnt), 0);
        check_eq("rst_ready", int'(bus.cmd_ready), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, 2'h0, '0, '0, 1'b1);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_err = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.issue_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single add: one cycle of latency, then outputs return to zero.
        step(1'b1, 2'h1, 6'd5, 6'd3, 1'b1);
        step(1'b0, 2'h0, '0, '0, 1'b1);
        step(1'b0, 2'h0, '0, '0, 1'b1);

        // Fill while stalled, hold off a fifth, then pop-while-full (no bypass).
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'h2, 6'(10 + i), 6'd1, 1'b0);
        end
        step(1'b1, 2'h1, 6'd20, 6'd21, 1'b0);
        step(1'b1, 2'h1, 6'd20, 6'd21, 1'b1);
        step(1'b1, 2'h1, 6'd20, 6'd21, 1'b1);
        drain();

        // Simultaneous push and pop at count 2.
        step(1'b1, 2'h1, 6'd1, 6'd2, 1'b0);
        step(1'b1, 2'h2, 6'd3, 6'd4, 1'b0);
        step(1'b1, 2'h0, 6'd5, 6'd6, 1'b1);
        step(1'b1, 2'h1, 6'd7, 6'd8, 1'b1);
        drain();

        // Pointer wrap over ten mixed pushes.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'(i % 3), 6'(3 * i + 1), 6'(63 - i), 1'(i % 2));
        end
        drain();

        // Illegal op leaves no gap; then saturate the error counter.
        step(1'b1, 2'h3, 6'd9, 6'd9, 1'b0);
        step(1'b1, 2'h1, 6'd7, 6'd7, 1'b0);
        drain();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'h3, 6'(i), 6'(i), 1'b1);
        end
        step(1'b1, 2'h2, 6'd44, 6'd4, 1'b1);
        step(1'b0, 2'h0, '0, '0, 1'b1);

        // Reset mid-burst with outputs active.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'h1, 6'(30 + i), 6'd2, 1'b0);
        end
        step(1'b0, 2'h0, '0, '0, 1'b1);
        do_reset();
        step(1'b1, 2'h2, 6'd50, 6'd5, 1'b1);
        step(1'b0, 2'h0, '0, '0, 1'b1);
        step(1'b0, 2'h0, '0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 6'($urandom), 6'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Upstream issue stage for the registered add/sub ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues at most one command per cycle to the ALU input port (op, a, b, valid), and only while the issue_en throttle is high.
- Filters illegal opcodes and counts them.

Parameters:
- WIDTH, 6, operand width; must equal the ALU WIDTH.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_op  input  2  command opcode: 2'h0 nop, 2'h1 add, 2'h2 sub, 2'h3 illegal.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  queue can accept a command this cycle.
- issue_en  input  1  downstream permits issue this cycle.
- op_out  output  2  opcode to ALU op_in.
- a_out  output  WIDTH  operand to ALU a_in.
- b_out  output  WIDTH  operand to ALU b_in.
- out_valid  output  1  to ALU in_valid.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err_cnt  output  8  saturating count of illegal commands.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high: it is sampled on the rising edge of clk and overrides all other activity on that edge.
- Reset values:
  - op_out=2'h0, a_out=0, b_out=0, out_valid=0.
  - count=0, err_cnt=0.
  - FIFO read and write pointers = 0. FIFO contents need no reset.
- cmd_ready:
  - Equals (count != DEPTH).
  - Combinational from registered state only; it never depends on cmd_valid or issue_en.
  - While full, cmd_ready=0 even when a pop happens in the same cycle. There is no full-bypass.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - An accepted legal command (cmd_op != 2'h3) is written at the write pointer, and the write pointer increments, wrapping modulo DEPTH.
  - nop (2'h0) is a legal command: it is queued and issued like add or sub.
  - An accepted illegal command (2'h3) is consumed but not stored. err_cnt increments and saturates at 8'hFF. count is unchanged.
- Issue (pop):
  - Pop on an edge where issue_en && count != 0.
  - On a pop edge, the outputs register the head entry: op_out, a_out and b_out take the head values and out_valid=1. The read pointer then increments, wrapping modulo DEPTH.
  - On any non-pop edge: out_valid=0, op_out=2'h0, a_out=0, b_out=0.
- Occupancy:
  - count increments on a legal push only, decrements on a pop only, and is unchanged when both happen on the same edge.
  - No overflow or underflow is possible by construction.
- Latency:
  - A command accepted on edge k is held in the FIFO from edge k onward; count reflects it on the same edge.
  - Its earliest pop edge is k+1, so its outputs are visible after edge k+1, i.e. minimum 1 cycle after acceptance.
  - There is no same-edge pass-through from an empty queue.
- Ordering: strict FIFO. Illegal commands leave no gap in the order.
- Reset mid-operation:
  - All queued entries are discarded and outputs return to reset values on that edge.
  - A command presented on the reset edge is not accepted, and err_cnt does not change.
- Stall: while issue_en=0 the queue holds its contents and out_valid=0.

Test Plan:
- Reset then single add: push op=1, a=5, b=3 on edge 1 with issue_en=1 -> count=1 after edge 1; after edge 2 op_out=1, a_out=5, b_out=3, out_valid=1, count=0; after edge 3 out_valid=0 and all outputs 0.
- Fill with stall: issue_en=0, push 4 subs with a=10..13, b=1 -> count=4, cmd_ready=0. A 5th command is held off. Raise issue_en -> 4 consecutive valid outputs with a_out=10,11,12,13 in order, then cmd_ready=1.
- Simultaneous push and pop at count=2 -> count stays 2. Pointer wrap over 10 mixed pushes (DEPTH=4) -> issue order matches push order exactly.
- Illegal op: push op=3, then op=1 (a=7, b=7) -> err_cnt=1, count=1, only the add is issued. 300 illegal pushes -> err_cnt saturates at 8'hFF.
- Full with pop, no bypass: at count=4 with issue_en=1 and cmd_valid=1 -> cmd_ready=0 on that cycle, count=3 after the edge, and the command is accepted on the next edge.
- Reset mid-burst: count=3 with out_valid=1, assert rst for 1 cycle -> count=0, out_valid=0, op_out=0, err_cnt=0. A command on the reset edge is not accepted. The next push is issued normally.
